// File: rtl/mbist_def.sv
// rtl/mbist_def.sv - shared state encoding, default sizes and error-count helper for the MBIST pattern controller
package mbist_def;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      NEXT,
      DONE
   } bist_state_e;

   localparam int BIST_ADDR_WD_DEF = 9;
   localparam int BIST_DATA_WD_DEF = 32;
   localparam int BIST_RD_LAT_DEF  = 1;
   localparam int BIST_PAT_CNT_DEF = 8;

   localparam int ERR_CNT_WD = 8;
   localparam logic [ERR_CNT_WD-1:0] ERR_CNT_MAX = '1;

   function automatic logic [ERR_CNT_WD-1:0] sat_inc(input logic [ERR_CNT_WD-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mbist_rd_pipe.sv
// rtl/mbist_rd_pipe.sv - LAT-deep {valid, addr} delay line aligning issued reads with returning data
module mbist_rd_pipe #(
   parameter int AW  = 9,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_vld,
   input  logic [AW-1:0] in_addr,
   output logic          out_vld,
   output logic [AW-1:0] out_addr
);

   logic [LAT-1:0]         vld_q, vld_d;
   logic [LAT-1:0][AW-1:0] addr_q, addr_d;

   always_comb begin
      vld_d  = '0;
      addr_d = '0;
      if (!flush) begin
         vld_d[0]  = in_vld;
         addr_d[0] = in_addr;
         for (int i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         addr_q <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   assign out_vld  = vld_q[LAT-1];
   assign out_addr = addr_q[LAT-1];

endmodule

// File: rtl/mbist_pat_ctrl.sv
// rtl/mbist_pat_ctrl.sv - per-memory MBIST write/read/compare sequencer; MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch
module mbist_pat_ctrl
   import mbist_def::*;
#(
   parameter int BIST_ADDR_WD = BIST_ADDR_WD_DEF,
   parameter int BIST_DATA_WD = BIST_DATA_WD_DEF,
   parameter int BIST_RD_LAT  = BIST_RD_LAT_DEF,
   parameter int BIST_PAT_CNT = BIST_PAT_CNT_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            bist_en,
   input  logic                            bist_start,
   input  logic [BIST_DATA_WD-1:0]         pat_data,
   input  logic                            pat_last,
   output logic                            pat_run,
   output logic                            mem_cs,
   output logic                            mem_we,
   output logic [BIST_ADDR_WD-1:0]         mem_addr,
   output logic [BIST_DATA_WD-1:0]         mem_wdata,
   input  logic [BIST_DATA_WD-1:0]         mem_rdata,
   output logic                            bist_busy,
   output logic                            bist_done,
   output logic                            bist_fail,
   output logic [BIST_ADDR_WD-1:0]         fail_addr,
   output logic [$clog2(BIST_PAT_CNT)-1:0] fail_pat,
   output logic [ERR_CNT_WD-1:0]           err_cnt
);

   localparam int PAT_WD = $clog2(BIST_PAT_CNT);
   localparam logic [BIST_ADDR_WD-1:0] ADDR_MAX = '1;
   localparam logic [2:0] DRN_LAST = 3'(BIST_RD_LAT - 1);

   bist_state_e               state_q, state_d;
   logic [BIST_ADDR_WD-1:0]   addr_q, addr_d;
   logic [2:0]                drn_q, drn_d;
   logic [PAT_WD-1:0]         pat_idx_q, pat_idx_d;
   logic                      fail_q, fail_d;
   logic [BIST_ADDR_WD-1:0]   fail_addr_q, fail_addr_d;
   logic [PAT_WD-1:0]         fail_pat_q, fail_pat_d;
   logic [ERR_CNT_WD-1:0]     err_q, err_d;

   logic                      cmp_vld;
   logic [BIST_ADDR_WD-1:0]   cmp_addr;
   logic                      mismatch;
   logic                      pipe_flush;

   // Returning data is only judged while enabled, so an abort discards in-flight reads.
   assign mismatch = bist_en && cmp_vld && (mem_rdata != pat_data);

`ifdef MBIST_STOP_ON_FAIL_EN
   assign pipe_flush = !bist_en || mismatch;
`else
   assign pipe_flush = !bist_en;
`endif

   mbist_rd_pipe #(
      .AW  (BIST_ADDR_WD),
      .LAT (BIST_RD_LAT)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .flush    (pipe_flush),
      .in_vld   (state_q == READ),
      .in_addr  (addr_q),
      .out_vld  (cmp_vld),
      .out_addr (cmp_addr)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      drn_d       = drn_q;
      pat_idx_d   = pat_idx_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_pat_d  = fail_pat_q;
      err_d       = err_q;

      if (mismatch) begin
         err_d = sat_inc(err_q);
         if (!fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr;
            fail_pat_d  = pat_idx_q;
         end
      end

      if (!bist_en) begin
         state_d = IDLE;
         addr_d  = '0;
         drn_d   = '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (bist_start) begin
                  state_d     = WRITE;
                  addr_d      = '0;
                  pat_idx_d   = '0;
                  fail_d      = 1'b0;
                  fail_addr_d = '0;
                  fail_pat_d  = '0;
                  err_d       = '0;
               end
            end
            WRITE: begin
               addr_d = addr_q + 1'b1;
               if (addr_q == ADDR_MAX) state_d = READ;
            end
            READ: begin
               addr_d = addr_q + 1'b1;
               if (addr_q == ADDR_MAX) begin
                  state_d = DRAIN;
                  drn_d   = '0;
               end
            end
            DRAIN: begin
               if (drn_q == DRN_LAST) state_d = NEXT;
               else                   drn_d   = drn_q + 1'b1;
            end
            NEXT: begin
               if (pat_last) begin
                  state_d = DONE;
               end else begin
                  pat_idx_d = pat_idx_q + 1'b1;
                  state_d   = WRITE;
               end
            end
            default: state_d = IDLE;
         endcase
`ifdef MBIST_STOP_ON_FAIL_EN
         if (mismatch) state_d = DONE;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         drn_q       <= '0;
         pat_idx_q   <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_pat_q  <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         drn_q       <= drn_d;
         pat_idx_q   <= pat_idx_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_pat_q  <= fail_pat_d;
         err_q       <= err_d;
      end
   end

   assign mem_cs    = (state_q == WRITE) || (state_q == READ);
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = mem_we ? pat_data : '0;
   assign pat_run   = (state_q == NEXT);
   assign bist_busy = (state_q != IDLE) && (state_q != DONE);
   assign bist_done = (state_q == DONE);
   assign bist_fail = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_pat  = fail_pat_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_mbist_pat_ctrl.sv
// tb/tb_mbist_pat_ctrl.sv - self-checking bench for mbist_pat_ctrl with memory, selector and fault models
module tb_mbist_pat_ctrl;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int NP  = 8;
   localparam int N   = 1 << AW;
   localparam int P   = 2 * N + LAT + 1;

   typedef struct {
      int mode;
      int faddr;
      int fpat;
      int exp_cyc;
      int exp_fail;
      int exp_faddr;
      int exp_fpat;
      int exp_err;
      int exp_pr;
      int exp_drain;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bist_en = 1'b0;
   logic          bist_start = 1'b0;
   logic [DW-1:0] pat_data;
   logic          pat_last;
   logic          pat_run;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          bist_busy;
   logic          bist_done;
   logic          bist_fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_pat;
   logic [7:0]    err_cnt;

   mbist_pat_ctrl #(
      .BIST_ADDR_WD (AW),
      .BIST_DATA_WD (DW),
      .BIST_RD_LAT  (LAT),
      .BIST_PAT_CNT (NP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bist_en    (bist_en),
      .bist_start (bist_start),
      .pat_data   (pat_data),
      .pat_last   (pat_last),
      .pat_run    (pat_run),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .bist_busy  (bist_busy),
      .bist_done  (bist_done),
      .bist_fail  (bist_fail),
      .fail_addr  (fail_addr),
      .fail_pat   (fail_pat),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [DW-1:0] pat_pick(input int p);
      case (p)
         0: return 32'hFFFF_FFFF;
         1: return 32'h0000_0000;
         2: return 32'hAAAA_AAAA;
         3: return 32'h5555_5555;
         4: return 32'h0F0F_0F0F;
         5: return 32'hF0F0_F0F0;
         6: return 32'h3333_3333;
         default: return 32'hCCCC_CCCC;
      endcase
   endfunction

   // mode 1: bit0 stuck-at-1 at faddr; 2: every word inverted; 3: bit8 flipped at last address in pattern fpat
   function automatic logic [DW-1:0] fault_rd(input int md, input int fa, input int fp,
                                              input int a, input int p, input logic [DW-1:0] d);
      case (md)
         1: return (a == fa) ? (d | 32'h1) : d;
         2: return ~d;
         3: return (a == N - 1 && p == fp) ? (d ^ 32'h100) : d;
         default: return d;
      endcase
   endfunction

   // Pattern selector model; sel_rst re-scans it to pattern 0
   int   pos = 0;
   logic sel_rst = 1'b0;
   always @(posedge clk) begin
      if (sel_rst)      pos <= 0;
      else if (pat_run) pos <= (pos == NP - 1) ? 0 : pos + 1;
   end
   assign pat_data = pat_pick(pos);
   assign pat_last = (pos == NP - 1);

   // Memory model with fault injection on read and LAT-cycle read pipeline
   int            f_mode = 0;
   int            f_addr = 0;
   int            f_pat  = 0;
   logic [DW-1:0] mem [N];
   logic [DW-1:0] rd_sr [LAT];
   always @(posedge clk) begin
      if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
      rd_sr[0] <= (mem_cs && !mem_we) ?
                  fault_rd(f_mode, f_addr, f_pat, int'(mem_addr), pos, mem[mem_addr]) : '0;
      for (int i = 1; i < LAT; i++) rd_sr[i] <= rd_sr[i-1];
   end
   assign mem_rdata = rd_sr[LAT-1];

   int   cyc = 0;
   int   pr_cnt = 0;
   int   drn_cnt = 0;
   int   bad_cnt = 0;
   logic pr_prev = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (pat_run) pr_cnt <= pr_cnt + 1;
      if (bist_busy && !mem_cs) drn_cnt <= drn_cnt + 1;
      if ((mem_cs && mem_we && mem_wdata !== pat_pick(pos)) || (pat_run && pr_prev))
         bad_cnt <= bad_cnt + 1;
      pr_prev <= pat_run;
   end

   function automatic vec_t build(input int md, input int fa, input int fp);
      vec_t v;
      int   cnt = 0;
      int   fp_first = -1;
      int   fa_first = 0;
      v.mode = md; v.faddr = fa; v.fpat = fp;
      for (int p = 0; p < NP; p++)
         for (int a = 0; a < N; a++)
            if (fault_rd(md, fa, fp, a, p, pat_pick(p)) != pat_pick(p)) begin
               if (fp_first < 0) begin fp_first = p; fa_first = a; end
               cnt++;
            end
      v.exp_fail  = (cnt > 0) ? 1 : 0;
      v.exp_faddr = fa_first;
      v.exp_fpat  = (fp_first < 0) ? 0 : fp_first;
      v.exp_err   = (cnt > 255) ? 255 : cnt;
      v.exp_cyc   = NP * P + 1;
      v.exp_pr    = NP;
      v.exp_drain = NP * (LAT + 1);
`ifdef MBIST_STOP_ON_FAIL_EN
      if (cnt > 0) begin
         v.exp_err   = 1;
         v.exp_cyc   = fp_first * P + N + fa_first + LAT + 2;
         v.exp_pr    = fp_first;
         v.exp_drain = fp_first * (LAT + 1) + ((fa_first + 1 + LAT - N > 0) ? fa_first + 1 + LAT - N : 0);
      end
`endif
      return v;
   endfunction

   vec_t vecs [4];
   vec_t exp_q [$];

   task automatic sel_rescan();
      @(negedge clk); sel_rst = 1'b1;
      @(negedge clk); sel_rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      vec_t e;
      int   t0, el, b_pr, b_dr, b_bad;
      bit   got;
      f_mode = v.mode; f_addr = v.faddr; f_pat = v.fpat;
      sel_rescan();
      b_pr = pr_cnt; b_dr = drn_cnt; b_bad = bad_cnt;
      bist_start = 1'b1; t0 = cyc;
      exp_q.push_back(v);
      @(negedge clk); bist_start = 1'b0;
      got = 0; el = 0;
      for (int k = 0; k < 5000 && !got; k++) begin
         el = cyc - t0;
         if (bist_done) got = 1;
         else begin
            bist_start = (el == 50);
            @(negedge clk);
         end
      end
      bist_start = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("v%0d done_seen", e.mode), int'(got), 1);
      check($sformatf("v%0d done_cycle", e.mode), el, e.exp_cyc);
      check($sformatf("v%0d bist_fail", e.mode), int'(bist_fail), e.exp_fail);
      check($sformatf("v%0d fail_addr", e.mode), int'(fail_addr), e.exp_faddr);
      check($sformatf("v%0d fail_pat", e.mode), int'(fail_pat), e.exp_fpat);
      check($sformatf("v%0d err_cnt", e.mode), int'(err_cnt), e.exp_err);
      check($sformatf("v%0d pat_run_pulses", e.mode), pr_cnt - b_pr, e.exp_pr);
      check($sformatf("v%0d drain_next_cycles", e.mode), drn_cnt - b_dr, e.exp_drain);
      check($sformatf("v%0d wdata_pulse_errs", e.mode), bad_cnt - b_bad, 0);
   endtask

   initial begin
      int snap;
      bit hit;
      for (int i = 0; i < 4; i++) vecs[i] = build(i, 5, 3);

      repeat (3) @(negedge clk);
      check("rst busy", int'(bist_busy), 0);
      check("rst done", int'(bist_done), 0);
      check("rst fail", int'(bist_fail), 0);
      check("rst err_cnt", int'(err_cnt), 0);
      check("rst cs", int'(mem_cs), 0);
      check("rst pat_run", int'(pat_run), 0);
      check("rst mem_addr", int'(mem_addr), 0);
      rst = 1'b0;
      bist_en = 1'b1;

      // Abort during READ at address 7
`ifdef MBIST_STOP_ON_FAIL_EN
      f_mode = 0;
`else
      f_mode = 2;
`endif
      sel_rescan();
      bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
      hit = 0;
      for (int k = 0; k < 500 && !hit; k++) begin
         if (mem_cs && !mem_we && mem_addr == 7) hit = 1;
         else @(negedge clk);
      end
      check("abort reached_read7", int'(hit), 1);
      bist_en = 1'b0;
      @(negedge clk);
      check("abort busy", int'(bist_busy), 0);
      check("abort cs", int'(mem_cs), 0);
      check("abort pat_run", int'(pat_run), 0);
      check("abort done", int'(bist_done), 0);
`ifdef MBIST_STOP_ON_FAIL_EN
      check("abort err_cnt", int'(err_cnt), 0);
`else
      check("abort err_cnt", int'(err_cnt), 7 - LAT);
`endif
      snap = int'(err_cnt);
      bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
      check("start_while_disabled busy", int'(bist_busy), 0);
      repeat (5) @(negedge clk);
      check("abort err_cnt_held", int'(err_cnt), snap);
      bist_en = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      repeat (4) @(negedge clk);
      check("done held", int'(bist_done), 1);
      bist_en = 1'b0;
      @(negedge clk);
      check("done dropped_on_disable", int'(bist_done), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
